// File: rtl/fifo_pkg.sv
// Shared definitions for the block-RAM FWFT FIFO: count width helper and RAM read latency.
package fifo_pkg;

    localparam int RAM_LATENCY = 1;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dual_port_bram.sv
// True dual-port block RAM, single clock, registered read port B, no_change write mode on both ports.
module dual_port_bram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int LATENCY    = 1,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  wea,
    input  logic [ADDR_W-1:0]     addra,
    input  logic [DATA_WIDTH-1:0] dina,
    input  logic                  enb,
    input  logic                  web,
    input  logic [ADDR_W-1:0]     addrb,
    input  logic [DATA_WIDTH-1:0] dinb,
    output logic [DATA_WIDTH-1:0] doutb
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (ena && wea) begin
            mem[addra] <= dina;
        end
        if (enb && web) begin
            mem[addrb] <= dinb;
        end
    end

    // Output register resets synchronously and holds its value whenever port B is idle or writing.
    generate
        if (LATENCY == 1) begin : g_lat1
            always_ff @(posedge clk) begin
                if (rst) begin
                    doutb <= '0;
                end else if (enb && !web) begin
                    doutb <= mem[addrb];
                end
            end
        end else begin : g_unsupported
            assign doutb = '0;
        end
    endgenerate

endmodule

// File: rtl/bram_fwft_fifo.sv
// First-word-fall-through FIFO over a 1-cycle-latency dual-port RAM; the RAM output register is the head stage.
module bram_fwft_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    localparam int CNT_W     = cnt_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  full,
    input  logic                  pop,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] ram_cnt_q, ram_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wr_en, rd_en, pop_acc;

    assign count     = ram_cnt_q + CNT_W'(out_valid_q);
    assign full      = (count == CNT_W'(DEPTH));
    assign valid     = out_valid_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    assign wr_en   = push && !full && !flush;
    assign pop_acc = pop && out_valid_q && !flush;
    // A read is only issued for words already written, so ports A and B never share an address.
    assign rd_en   = (ram_cnt_q != '0) && (!out_valid_q || pop_acc) && !flush;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ram_cnt_d   = ram_cnt_q;
        out_valid_d = out_valid_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            ram_cnt_d   = '0;
            out_valid_d = 1'b0;
        end else begin
            overflow_d  = push && full;
            underflow_d = pop && !out_valid_q;
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            ram_cnt_d = ram_cnt_q + CNT_W'(wr_en) - CNT_W'(rd_en);
            if (rd_en) begin
                out_valid_d = 1'b1;
            end else if (pop_acc) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_cnt_q   <= ram_cnt_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    dual_port_bram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .LATENCY    (RAM_LATENCY)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .ena   (wr_en),
        .wea   (wr_en),
        .addra (wr_ptr_q),
        .dina  (push_data),
        .enb   (rd_en),
        .web   (1'b0),
        .addrb (rd_ptr_q),
        .dinb  ('0),
        .doutb (pop_data)
    );

endmodule

// File: tb/tb_bram_fwft_fifo.sv
// Self-checking bench for bram_fwft_fifo: directed and random traffic against a queue model with
// per-entry visibility times (an entry shows one edge after its write edge, never before its predecessor leaves).
module tb_bram_fwft_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          push;
    logic [DW-1:0] push_data;
    logic          pop;
    logic          full;
    logic          valid;
    logic [DW-1:0] pop_data;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;

    int checks;
    int fails;
    int edge_cnt;

    logic [DW-1:0] mq[$];
    int            wq[$];
    int            gate;
    bit            exp_ovf;
    bit            exp_unf;

    bram_fwft_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .push_data (push_data),
        .full      (full),
        .pop       (pop),
        .valid     (valid),
        .pop_data  (pop_data),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before the sequence completed");
        $fatal(1, "[TB] timeout");
    end

    function automatic bit modelValid();
        int vis;
        if (mq.size() == 0) return 1'b0;
        vis = wq[0] + 1;
        if (gate > vis) vis = gate;
        return vis <= edge_cnt;
    endfunction

    task automatic modelReset();
        mq.delete();
        wq.delete();
        gate    = 0;
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic checkAll();
        bit v;
        v = modelValid();
        checkOutput("count", 64'(count), 64'(mq.size()));
        checkOutput("full", 64'(full), 64'(mq.size() == DEPTH));
        checkOutput("valid", 64'(valid), 64'(v));
        checkOutput("overflow", 64'(overflow), 64'(exp_ovf));
        checkOutput("underflow", 64'(underflow), 64'(exp_unf));
        if (v) checkOutput("pop_data", 64'(pop_data), 64'(mq[0]));
    endtask

    // One clock cycle: check the state left by the previous edge, advance the model, drive the next inputs.
    task automatic applyStimulus(input logic p, input logic [DW-1:0] d, input logic po, input logic fl);
        bit v;
        bit f;
        @(negedge clk);
        checkAll();
        if (fl) begin
            modelReset();
        end else begin
            v       = modelValid();
            f       = (mq.size() == DEPTH);
            exp_ovf = p && f;
            exp_unf = po && !v;
            if (po && v) begin
                void'(mq.pop_front());
                void'(wq.pop_front());
                gate = edge_cnt + 1;
            end
            if (p && !f) begin
                mq.push_back(d);
                wq.push_back(edge_cnt + 1);
            end
        end
        push      = p;
        push_data = d;
        pop       = po;
        flush     = fl;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_valid"}, 64'(valid), 64'(0));
        checkOutput({tag, "_full"}, 64'(full), 64'(0));
        checkOutput({tag, "_count"}, 64'(count), 64'(0));
        checkOutput({tag, "_overflow"}, 64'(overflow), 64'(0));
        checkOutput({tag, "_underflow"}, 64'(underflow), 64'(0));
    endtask

    // Raise rst between edges, confirm the outputs clear at once, and hold it across one edge.
    task automatic asyncReset();
        @(posedge clk);
        #2;
        push  = 1'b0;
        pop   = 1'b0;
        flush = 1'b0;
        rst   = 1'b1;
        #1;
        checkResetState("async_rst");
        modelReset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        checks    = 0;
        fails     = 0;
        edge_cnt  = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        push_data = '0;
        modelReset();
        #1;
        checkResetState("por");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1: four pushes, head falls through two edges after the first
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, DW'(32'hA0 + i), 1'b0, 1'b0);
        idle(3);

        // 2: fill to DEPTH, one dropped push, then drain at one pop per cycle
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, DW'(i), 1'b0, 1'b0);
        applyStimulus(1'b1, DW'(32'hFF), 1'b0, 1'b0);
        idle(2);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
        idle(2);

        // 3: prefill three, then streaming push+pop long enough to wrap the pointers
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, DW'(32'hB0 + i), 1'b0, 1'b0);
        idle(2);
        for (int i = 0; i < 40; i++) applyStimulus(1'b1, DW'($urandom), 1'b1, 1'b0);
        idle(1);

        // 4: drain to one entry, then push 0x55 together with the last pop
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b1, DW'(32'h55), 1'b1, 1'b0);
        idle(3);

        // 5: pop on empty, then flush with five held entries and a concurrent push
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        idle(2);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        idle(2);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, DW'(32'hC0 + i), 1'b0, 1'b0);
        idle(2);
        applyStimulus(1'b1, DW'(32'hDEAD), 1'b0, 1'b1);
        idle(3);

        // Random traffic, including occasional illegal pops and flushes
        for (int i = 0; i < 200; i++) begin
            applyStimulus($urandom_range(0, 99) < 60, DW'($urandom),
                          $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 2);
        end

        // 6: asynchronous reset mid-stream, then a fresh entry with no stale data
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, DW'($urandom), i[0], 1'b0);
        asyncReset();
        applyStimulus(1'b1, DW'(32'h77), 1'b0, 1'b0);
        idle(3);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        idle(2);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
